// File: rtl/alu_control_mdu.sv
// Execute-stage control: ALU opcode decode plus an iterative
// shift-add / restoring-divide M-extension unit with pipeline stall.
module alu_control_mdu #(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [3:0]      ALUOp,
  input  logic [3:0]      bits,
  input  logic            mext,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic [3:0]      salida_ALUcontrol,
  output logic            stall,
  output logic            mdu_valid,
  output logic [XLEN-1:0] mdu_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};

  always_comb begin
    salida_ALUcontrol = 4'b0000;
    unique case (ALUOp)
      4'b0000: begin
        if (!mext) begin
          case (bits)
            4'b1000: salida_ALUcontrol = 4'b0111;
            4'b0001: salida_ALUcontrol = 4'b1000;
            4'b0010: salida_ALUcontrol = 4'b0100;
            4'b0011: salida_ALUcontrol = 4'b1101;
            4'b0100: salida_ALUcontrol = 4'b1001;
            4'b0101: salida_ALUcontrol = 4'b1010;
            4'b1101: salida_ALUcontrol = 4'b1110;
            4'b0110: salida_ALUcontrol = 4'b0001;
            4'b0111: salida_ALUcontrol = 4'b0010;
            default: salida_ALUcontrol = 4'b0000;
          endcase
        end
      end
      4'b1100: begin
        case (bits[2:0])
          3'b001:  salida_ALUcontrol = 4'b1000;
          3'b010:  salida_ALUcontrol = 4'b0100;
          3'b011:  salida_ALUcontrol = 4'b1101;
          3'b100:  salida_ALUcontrol = 4'b1001;
          3'b101:  salida_ALUcontrol = bits[3] ? 4'b1110 : 4'b1010;
          3'b110:  salida_ALUcontrol = 4'b0001;
          3'b111:  salida_ALUcontrol = 4'b0010;
          default: salida_ALUcontrol = 4'b0000;
        endcase
      end
      4'b1111: begin
        if (bits[2:0] == 3'b000) salida_ALUcontrol = 4'b1111;
        else if (bits[2:0] == 3'b001) salida_ALUcontrol = 4'b0011;
      end
      default: salida_ALUcontrol = 4'b0000;
    endcase
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_res;

  logic [2:0]        w_op;
  logic              w_start, w_sa, w_sb, w_na, w_nb, w_dz, w_ovf;
  logic [XLEN-1:0]   w_ma, w_mb;
  logic [XLEN:0]     w_add, w_rsh, w_diff;
  logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_prod;
  logic [XLEN-1:0]   w_q, w_r, w_res;

  assign w_op    = bits[2:0];
  assign w_start = M_EXT && valid_in && mext && (ALUOp == 4'b0000)
                   && (r_state == S_IDLE) && !flush;

  // Signed operands: MULH/MULHSU/DIV/REM for A, MULH/DIV/REM for B.
  assign w_sa = w_op[2] ? ~w_op[0] : (w_op[1] ^ w_op[0]);
  assign w_sb = (w_op == 3'b001) || (w_op[2] && !w_op[0]);
  assign w_na = w_sa && opA[XLEN-1];
  assign w_nb = w_sb && opB[XLEN-1];
  assign w_ma = w_na ? -opA : opA;
  assign w_mb = w_nb ? -opB : opB;
  assign w_dz = w_op[2] && (opB == ZERO);
  assign w_ovf = w_op[2] && !w_op[0] && (opA == MINV) && (opB == ONES);

  assign w_add = {1'b0, r_acc[2*XLEN-1:XLEN]}
               + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
  assign w_mul_nxt = {w_add, r_acc[XLEN-1:1]};

  assign w_rsh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff = w_rsh - {1'b0, r_opnd};
  assign w_div_nxt = w_diff[XLEN]
    ? {w_rsh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
    : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_q = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_r = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_res = r_op[2] ? (r_op[1] ? w_r : w_q)
               : ((r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0]
                                       : w_prod[2*XLEN-1:XLEN]);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_res   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op  <= w_op;
            r_cnt <= '0;
            // Special divides are resolved here; fix-up is a pass-through.
            if (w_dz) begin
              r_acc   <= {opA, ONES};
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= S_DONE;
            end else if (w_ovf) begin
              r_acc   <= {ZERO, opA};
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_opnd  <= w_op[2] ? w_mb : w_ma;
              r_acc   <= {ZERO, (w_op[2] ? w_ma : w_mb)};
              r_neg_q <= w_na ^ w_nb;
              r_neg_r <= w_na;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_res   <= w_res;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall      = w_start || (r_state == S_CALC);
  assign mdu_valid  = (r_state == S_DONE) && !flush;
  assign mdu_result = mdu_valid ? w_res : r_res;

endmodule

// File: tb/tb_alu_control_mdu.sv
// Bench for alu_control_mdu: decode tables and an arithmetic
// reference model for the multiply/divide unit.
module tb_alu_control_mdu;
  localparam int XLEN = 32;

  logic        CLK = 1'b0;
  logic        RESET, valid_in, flush, mext;
  logic [3:0]  ALUOp, bits;
  logic [31:0] opA, opB;
  logic [3:0]  salida_ALUcontrol;
  logic        stall, mdu_valid;
  logic [31:0] mdu_result;

  int n_chk = 0;
  int n_pass = 0;

  logic [3:0] rtab [16];
  logic [3:0] itab [8];

  always #5 CLK = ~CLK;

  alu_control_mdu #(.XLEN(XLEN), .M_EXT(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .valid_in(valid_in), .flush(flush),
    .ALUOp(ALUOp), .bits(bits), .mext(mext), .opA(opA), .opB(opB),
    .salida_ALUcontrol(salida_ALUcontrol), .stall(stall),
    .mdu_valid(mdu_valid), .mdu_result(mdu_result)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] ref_dec(input logic [3:0] aop,
                                         input logic [3:0] b,
                                         input logic m);
    if (aop == 4'd0) return m ? 4'b0000 : rtab[b];
    if (aop == 4'd12)
      return (b[2:0] == 3'b101 && b[3]) ? 4'b1110 : itab[b[2:0]];
    if (aop == 4'd15)
      return (b[2:0] == 3'd0) ? 4'b1111 :
             (b[2:0] == 3'd1) ? 4'b0011 : 4'b0000;
    return 4'b0000;
  endfunction

  function automatic bit is_special(input logic [2:0] op,
                                    input logic [31:0] a, b);
    return op[2] && (b == 0 ||
           (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_mdu(input logic [2:0] op,
                                          input logic [31:0] a, b);
    longint      p;
    logic [63:0] pu;
    int          sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin
        p = longint'(sa) * longint'({32'b0, b});
        return p[63:32];
      end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (is_special(op, a, b)) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (is_special(op, a, b)) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b);
    int          lat, stalls, exp_lat;
    logic [31:0] got, exp;
    exp = ref_mdu(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : XLEN + 1;
    tick();
    valid_in = 1'b1; mext = 1'b1; ALUOp = 4'd0;
    bits = {1'b0, op}; opA = a; opB = b; flush = 1'b0;
    lat = -1; stalls = 0; got = '0;
    for (int i = 0; i <= XLEN + 4 && lat < 0; i++) begin
      @(negedge CLK);
      if (stall) stalls++;
      if (mdu_valid) begin
        lat = i;
        got = mdu_result;
      end else begin
        tick();
      end
    end
    check($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat));
    check($sformatf("result op%0d a=%h b=%h", op, a, b), got, exp);
    check($sformatf("stall cycles op%0d", op), 64'(stalls), 64'(exp_lat));
    tick();
    valid_in = 1'b0; mext = 1'b0;
    @(negedge CLK);
    check("valid single pulse", mdu_valid, 1'b0);
    check("result hold", mdu_result, exp);
  endtask

  initial begin
    int          pulses;
    logic [3:0]  ra, rb;
    logic        rm;
    logic [2:0]  rop;
    logic [31:0] a, b;

    foreach (rtab[i]) rtab[i] = 4'b0000;
    rtab[4'b1000] = 4'b0111; rtab[4'b0001] = 4'b1000;
    rtab[4'b0010] = 4'b0100; rtab[4'b0011] = 4'b1101;
    rtab[4'b0100] = 4'b1001; rtab[4'b0101] = 4'b1010;
    rtab[4'b1101] = 4'b1110; rtab[4'b0110] = 4'b0001;
    rtab[4'b0111] = 4'b0010;
    itab[0] = 4'b0000; itab[1] = 4'b1000; itab[2] = 4'b0100;
    itab[3] = 4'b1101; itab[4] = 4'b1001; itab[5] = 4'b1010;
    itab[6] = 4'b0001; itab[7] = 4'b0010;

    RESET = 1'b1; valid_in = 1'b0; flush = 1'b0; mext = 1'b0;
    ALUOp = 4'd0; bits = 4'd0; opA = '0; opB = '0;
    tick(); tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("reset stall", stall, 1'b0);
    check("reset valid", mdu_valid, 1'b0);
    check("reset result", mdu_result, 32'd0);

    ALUOp = 4'b0000; bits = 4'b1000; #1;
    check("dec R sub", salida_ALUcontrol, 4'b0111);
    bits = 4'b0011; #1;
    check("dec R sltu", salida_ALUcontrol, 4'b1101);
    mext = 1'b1; #1;
    check("dec R mext", salida_ALUcontrol, 4'b0000);
    mext = 1'b0; ALUOp = 4'b1100; bits = 4'b1101; #1;
    check("dec I srai", salida_ALUcontrol, 4'b1110);
    bits = 4'b1011; #1;
    check("dec I sltiu", salida_ALUcontrol, 4'b1101);
    ALUOp = 4'b1111; bits = 4'b1001; #1;
    check("dec bne", salida_ALUcontrol, 4'b0011);
    ALUOp = 4'b0101; bits = 4'b0111; #1;
    check("dec unlisted", salida_ALUcontrol, 4'b0000);
    for (int k = 0; k < 24; k++) begin
      ra = 4'($urandom_range(0, 15));
      if (k % 2 == 0) ra = (k % 4 == 0) ? 4'd0 : 4'd12;
      rb = 4'($urandom_range(0, 15));
      rm = 1'($urandom_range(0, 3) == 0);
      ALUOp = ra; bits = rb; mext = rm; #1;
      check($sformatf("dec rand %b/%b/%b", ra, rb, rm),
            salida_ALUcontrol, ref_dec(ra, rb, rm));
    end
    mext = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd6, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int k = 0; k < 12; k++) begin
      rop = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      run_op(rop, a, b);
    end

    // Flush of a DIV at t+10, then a fresh MUL at t+12.
    pulses = 0;
    tick();
    valid_in = 1'b1; mext = 1'b1; ALUOp = 4'd0; bits = 4'b0100;
    opA = 32'd100; opB = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (mdu_valid) pulses++;
      tick();
    end
    flush = 1'b1; valid_in = 1'b0;
    @(negedge CLK);
    if (mdu_valid) pulses++;
    tick();
    flush = 1'b0;
    @(negedge CLK);
    if (mdu_valid) pulses++;
    check("flush stall", stall, 1'b0);
    check("flush no valid", 64'(pulses), 64'd0);
    run_op(3'd0, 32'd3, 32'd4);

    // RESET at t+5 of a MUL.
    tick();
    valid_in = 1'b1; mext = 1'b1; ALUOp = 4'd0; bits = 4'b0000;
    opA = 32'd5; opB = 32'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      tick();
    end
    RESET = 1'b1; valid_in = 1'b0;
    @(negedge CLK);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("mid reset stall", stall, 1'b0);
    check("mid reset valid", mdu_valid, 1'b0);
    check("mid reset result", mdu_result, 32'd0);
    pulses = 0;
    for (int i = 0; i < XLEN + 8; i++) begin
      tick();
      @(negedge CLK);
      if (mdu_valid) pulses++;
    end
    check("no pulse after reset", 64'(pulses), 64'd0);
    check("result after reset", mdu_result, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_control_mdu.md
Name: alu_control_mdu

Overview:
- Execute-stage control block for the RV32I(M) core.
- Decodes ALUOp and instruction fields into the 4-bit ALU control code, so the ALU path keeps its existing encoding.
- Adds an XLEN-parametrised iterative multiply/divide unit (M extension) that stalls the pipeline while it computes.
- Sits between the main control unit / register-file read and the ALU / writeback mux.

Parameters:
- XLEN, 32, operand/result width (≥8, even).
- M_EXT, 1, 1 = M-extension ops executed here; 0 = mext ignored, MDU never starts.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous reset, active-high.
- valid_in  in  1  an instruction is present in execute this cycle.
- flush  in  1  kill the in-flight MDU operation (branch/exception).
- ALUOp  in  4  instruction class from main control.
- bits  in  4  {inst[30], inst[14:12]}.
- mext  in  1  funct7==0000001 (R-format only).
- opA  in  XLEN  rs1 value.
- opB  in  XLEN  rs2 value.
- salida_ALUcontrol  out  4  ALU operation code, combinational.
- stall  out  1  freeze pipeline stages upstream of execute.
- mdu_valid  out  1  mdu_result is valid this cycle; selects the MDU in the writeback mux.
- mdu_result  out  XLEN  MUL/DIV/REM result.

Behaviour:
- ALU code map:
  - ADD 0000, OR 0001, AND 0010, BNE 0011, SLT 0100, SUB 0111.
  - SLL 1000, XOR 1001, SRL 1010, SLTU 1101, SRA 1110, BEQ 1111.
- ALUOp 0000 (R): decode on bits.
  - SLTU (0011) → 1101 in both R and I formats.
  - When mext=1, output 0000.
- ALUOp 1100 (I): bits[3] ignored except for SRLI/SRAI.
- ALUOp 0001/0011/0111/1110 → 0000.
- ALUOp 1111: bits[2:0] 000 → 1111, 001 → 0011.
- Unlisted combinations → 0000.
- MDU start condition: valid_in & mext & ALUOp==0000 & M_EXT & state==IDLE.
  - Op selected by bits[2:0]: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- FSM IDLE → CALC → DONE → IDLE:
  - Start cycle t (IDLE): latch opA, opB, op; take magnitudes of signed operands; record result sign. stall=1 combinationally.
  - CALC: one bit per cycle for exactly XLEN cycles (t+1..t+XLEN).
    - Multiply: shift-add into a 2·XLEN accumulator.
    - Divide: restoring, with quotient and remainder registers.
    - Counter wraps to 0 on the final iteration. stall=1.
  - DONE at t+XLEN+1: stall=0, mdu_valid=1 for exactly one cycle, sign fix-up applied.
    - MUL: low half. MULH/MULHSU/MULHU: high half.
    - Quotient sign = sA^sB; remainder sign = sA.
    - Next state IDLE.
- Special cases, detected at start and jumping directly to DONE (latency 1, stall high only in cycle t):
  - Divide by zero: quotient = all ones; remainder = opA.
  - DIV/REM overflow (opA = −2^(XLEN−1), opB = −1): quotient = opA; remainder = 0.
- Signedness: MULHSU treats opA as signed and opB as unsigned.
- Pipeline holds operands stable during stall. The MDU uses latched copies only.
- After DONE, start is not re-accepted in the same cycle; the next start is possible from IDLE at t+XLEN+2.
- flush has priority over everything except RESET.
  - In any state: next state IDLE, no mdu_valid, stall=0 from the next cycle.
  - flush asserted in the start cycle cancels the start.
- RESET, including mid-operation: next cycle state=IDLE, counter=0, stall=0, mdu_valid=0, mdu_result=0.
- mdu_result holds its last value outside DONE; it is 0 after reset.
- M_EXT=0: stall and mdu_valid are constantly 0.

Test Plan:
- Decode sweep with mext=0:
  - ALUOp 0000, bits 1000 → 0111; bits 0011 → 1101.
  - ALUOp 1100, bits 1101 → 1110.
  - ALUOp 1111, bits x001 → 0011.
  - ALUOp 0101 → 0000.
- MUL, XLEN=32: opA=7, opB=0xFFFFFFFD, start at t.
  - stall=1 t..t+32.
  - mdu_valid=1 only at t+33, result 0xFFFFFFEB.
- High products:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Division:
  - DIV −7/2 → 0xFFFFFFFD; REM −7%2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
  - Divide by zero: DIVU 5/0 → 0xFFFFFFFF at t+1; REM 5/0 → 5.
  - Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000 at t+1; REM → 0.
- flush at t+10 of a DIV:
  - t+11: IDLE, stall=0, mdu_valid never asserted.
  - New MUL 3×4 at t+12 → 12 at t+45.
- RESET at t+5 of a MUL:
  - t+6: stall=0, mdu_valid=0, mdu_result=0.
  - No mdu_valid pulse afterwards.
